// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one single-port, synchronous-read data memory between the
//            processor core and the loader/debug port. Grants are
//            combinational. Read data returns one cycle after the grant and is
//            steered to the requester that issued the read.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DWIDTH    data word width
//   AWIDTH    data-memory address width
//   MAXBURST  max consecutive loader grants while the core waits (1..15)
// Ports
//   clk, reset                           clock, async active-low reset
//   cpu_req/we/addr/wdata   -> in        core request
//   cpu_gnt                 -> out       core granted this cycle (comb.)
//   cpu_rvalid/rdata        -> out       core read return (registered valid)
//   ldr_req/we/addr/wdata   -> in        loader request
//   ldr_gnt                 -> out       loader granted this cycle (comb.)
//   ldr_rvalid/rdata        -> out       loader read return
//   mem_en/we/addr/wdata    -> out       memory command of the granted side
//   mem_rdata               -> in        memory read data (1-cycle latency)
// Build option
//   DMEM_ARB_ROUND_ROBIN_EN  when defined, contention alternates between the
//                            two requesters and the burst limiter is removed.
// ============================================================================
module dmem_arbiter #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 8,
  parameter int MAXBURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DWIDTH-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [AWIDTH-1:0] ldr_addr,
  input  logic [DWIDTH-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DWIDTH-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  // 0 = core, 1 = loader
  logic r_last_owner;
  logic r_rd_pend_cpu;
  logic r_rd_pend_ldr;
  logic w_cpu_gnt;
  logic w_ldr_gnt;

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] c_max_burst = 4'(MAXBURST);
  logic [3:0] r_burst_cnt;
`endif

  // Grant decision. The reset term masks grants while reset is held so the
  // memory sees no command during reset.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ldr_gnt = 1'b0;
    if (reset) begin
      if (cpu_req && ldr_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        // Winner is whoever did not own the memory last.
        if (r_last_owner) w_cpu_gnt = 1'b1;
        else              w_ldr_gnt = 1'b1;
`else
        // Loader has priority until it has used up its burst allowance.
        if (r_burst_cnt == c_max_burst) w_cpu_gnt = 1'b1;
        else                            w_ldr_gnt = 1'b1;
`endif
      end else if (cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (ldr_req) begin
        w_ldr_gnt = 1'b1;
      end
    end
  end

  assign cpu_gnt = w_cpu_gnt;
  assign ldr_gnt = w_ldr_gnt;

  // Memory command mux; zero when idle.
  always_comb begin
    mem_en    = w_cpu_gnt | w_ldr_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_ldr_gnt) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  // Owner tracking and read-return tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_owner  <= 1'b0;
      r_rd_pend_cpu <= 1'b0;
      r_rd_pend_ldr <= 1'b0;
    end else begin
      if (w_cpu_gnt)      r_last_owner <= 1'b0;
      else if (w_ldr_gnt) r_last_owner <= 1'b1;
      r_rd_pend_cpu <= w_cpu_gnt & ~cpu_we;
      r_rd_pend_ldr <= w_ldr_gnt & ~ldr_we;
    end
  end

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  // Counts loader grants taken while the core is waiting. Any core grant or
  // any cycle without a core request restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_burst_cnt <= 4'd0;
    end else if (!cpu_req || w_cpu_gnt) begin
      r_burst_cnt <= 4'd0;
    end else if (w_ldr_gnt && (r_burst_cnt != c_max_burst)) begin
      r_burst_cnt <= r_burst_cnt + 4'd1;
    end
  end
`endif

  assign cpu_rvalid = r_rd_pend_cpu;
  assign ldr_rvalid = r_rd_pend_ldr;
  assign cpu_rdata  = r_rd_pend_cpu ? mem_rdata : '0;
  assign ldr_rdata  = r_rd_pend_ldr ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a
//            synchronous-read memory model attached to the memory port.
//            Honours DMEM_ARB_ROUND_ROBIN_EN for the contention pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int DWIDTH   = 8;
  localparam int AWIDTH   = 8;
  localparam int MAXBURST = 4;

  logic              clk;
  logic              reset;
  logic              cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AWIDTH-1:0] cpu_addr, ldr_addr;
  logic [DWIDTH-1:0] cpu_wdata, ldr_wdata;
  logic              cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [DWIDTH-1:0] cpu_rdata, ldr_rdata;
  logic              mem_en, mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read, single-port memory.
  logic [DWIDTH-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_ldr(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = wd;
  endtask

  logic exp_ldr;
  logic prev_cpu_rd, prev_ldr_rd;

  initial begin
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_ldr(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset held with both requesting: every grant and return masked.
    @(negedge clk);
    set_cpu(1'b1, 1'b1, 8'h33, 8'h44);
    set_ldr(1'b1, 1'b1, 8'h55, 8'h66);
    #1;
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_ldr_gnt", ldr_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    @(negedge clk);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_ldr_rvalid", ldr_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ldr_rdata", ldr_rdata, 0);

    // Release reset; loader write granted in the very first active cycle.
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_ldr(1'b1, 1'b1, 8'h10, 8'h5A);
    #1;
    check("first_ldr_gnt", ldr_gnt, 1);
    check("first_mem_we", mem_we, 1);
    check("first_mem_addr", mem_addr, 8'h10);
    check("first_mem_wdata", mem_wdata, 8'h5A);

    // Preload 0x00..0x07 with 0xC0+i through the loader.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_ldr(1'b1, 1'b1, 8'(i), 8'(8'hC0 + i));
      #1;
      check("preload_gnt", ldr_gnt, 1);
    end

    // Idle: memory command zeroed.
    @(negedge clk);
    set_ldr(1'b0, 1'b0, 8'h77, 8'h88);
    #1;
    check("idle_mem_en", mem_en, 0);
    check("idle_mem_addr", mem_addr, 0);
    check("idle_mem_wdata", mem_wdata, 0);

    // Core read of 0x10.
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    check("rd10_cpu_gnt", cpu_gnt, 1);
    check("rd10_mem_we", mem_we, 0);
    check("rd10_mem_addr", mem_addr, 8'h10);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    check("rd10_cpu_rvalid", cpu_rvalid, 1);
    check("rd10_cpu_rdata", cpu_rdata, 8'h5A);
    check("rd10_ldr_rvalid", ldr_rvalid, 0);
    @(negedge clk);
    check("rd10_single_pulse", cpu_rvalid, 0);
    check("rd10_rdata_zero", cpu_rdata, 0);

    // Loader writes 0xA5 to 0x20, core reads it back.
    set_ldr(1'b1, 1'b1, 8'h20, 8'hA5);
    #1;
    check("wr20_mem_we", mem_we, 1);
    @(negedge clk);
    set_ldr(1'b0, 1'b0, 8'h00, 8'h00);
    set_cpu(1'b1, 1'b0, 8'h20, 8'h00);
    #1;
    check("rd20_mem_we", mem_we, 0);
    check("rd20_cpu_gnt", cpu_gnt, 1);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    check("wr_done_ldr_rvalid", ldr_rvalid, 0);
    check("rd20_cpu_rdata", cpu_rdata, 8'hA5);
    @(negedge clk);

    // Contention: both read continuously. Last grant was the core.
    set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    set_ldr(1'b1, 1'b0, 8'h00, 8'h00);
    prev_cpu_rd = 1'b0;
    prev_ldr_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_ldr = ((i % 2) == 0);
`else
      exp_ldr = ((i % 5) != 4);
`endif
      #1;
      check("cont_ldr_gnt", ldr_gnt, exp_ldr);
      check("cont_cpu_gnt", cpu_gnt, !exp_ldr);
      check("cont_cpu_rvalid", cpu_rvalid, prev_cpu_rd);
      check("cont_ldr_rvalid", ldr_rvalid, prev_ldr_rd);
      prev_cpu_rd = !exp_ldr;
      prev_ldr_rd = exp_ldr;
      @(negedge clk);
    end
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    set_ldr(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);

    // Loader only: 8 back-to-back reads of 0x00..0x07.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) set_ldr(1'b1, 1'b0, 8'(i), 8'h00);
      else       set_ldr(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      if (i < 8) check("burst_ldr_gnt", ldr_gnt, 1);
      if (i > 0) begin
        check("burst_ldr_rvalid", ldr_rvalid, 1);
        check("burst_ldr_rdata", ldr_rdata, 8'(8'hC0 + i - 1));
      end
      check("burst_cpu_rvalid", cpu_rvalid, 0);
      @(negedge clk);
    end
    check("burst_end_rvalid", ldr_rvalid, 0);

    // Core read granted, then reset before the edge that would return it.
    set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    check("rstmid_cpu_gnt", cpu_gnt, 1);
    #1;
    reset = 1'b0;
    #1;
    check("rstmid_gnt_masked", cpu_gnt, 0);
    check("rstmid_mem_en", mem_en, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstmid_cpu_rvalid", cpu_rvalid, 0);
      check("rstmid_cpu_rdata", cpu_rdata, 0);
      check("rstmid_mem_we", mem_we, 0);
    end
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("rstmid_after_rvalid", cpu_rvalid, 0);
    @(negedge clk);
    check("rstmid_after_rvalid2", cpu_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the processor core and a memory loader/debug port. It sits between the core's data-memory bus (address, write data, write enable) and the data memory. Each cycle it picks one requester, drives the memory, and returns read data one cycle later, tagged to the requester it granted. A burst limit stops the loader from starving the core.

## Interface
- DWIDTH, 8, data word width
- AWIDTH, 8, data-memory address width
- MAXBURST, 4, max consecutive loader grants while the core is requesting (1..15)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cpu_req  in  1  core requests a memory access this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AWIDTH  core address
- cpu_wdata  in  DWIDTH  core write data
- cpu_gnt  out  1  core access is performed this cycle (combinational)
- cpu_rvalid  out  1  registered; cpu_rdata is valid
- cpu_rdata  out  DWIDTH  read data for the core
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/AWIDTH/DWIDTH  loader request (same meaning as the core's)
- ldr_gnt  out  1  loader access is performed this cycle (combinational)
- ldr_rvalid  out  1  registered; ldr_rdata is valid
- ldr_rdata  out  DWIDTH  read data for the loader
- mem_en  out  1  memory access enable (= cpu_gnt | ldr_gnt)
- mem_we  out  1  write enable of the granted requester; 0 when not granted
- mem_addr  out  AWIDTH  address of the granted requester; 0 when idle
- mem_wdata  out  DWIDTH  write data of the granted requester; 0 when idle
- mem_rdata  in  DWIDTH  synchronous-read data, valid one cycle after the read

## Operation
- At most one grant per cycle. cpu_gnt and ldr_gnt are never both 1.
- Only one requester active: it is granted with no wait.
- Both requesting (contention), default policy: loader wins unless burst_cnt == MAXBURST, in which case the core wins.
- burst_cnt (4 bits):
  - increments on each loader grant while cpu_req = 1.
  - clears on any core grant.
  - clears on any cycle with cpu_req = 0.
  - saturates at MAXBURST.
- Registered state:
  - last_owner (0 = core, 1 = loader)
  - burst_cnt
  - rd_pend_cpu, rd_pend_ldr (one flop each)
- Read return: a granted read (we = 0) sets rd_pend for that requester for the next cycle.
  - x_rvalid = rd_pend_x.
  - x_rdata = mem_rdata when rd_pend_x = 1, else 0.
- Writes return nothing. A write is complete at the clock edge of its grant.
- A requester that is not granted must hold req, we, addr and wdata stable until it sees gnt.
- No outstanding-transaction limit beyond 1 per requester per cycle. Back-to-back reads from the same requester give back-to-back rvalid pulses.

## Timing
- Grant: combinational, same cycle as req. No added latency on the memory control path.
- Read latency: 1 cycle from grant to rvalid, with exactly one rvalid pulse per granted read.
- Reset values (reset = 0, asynchronous):
  - last_owner = 0, burst_cnt = 0, both rd_pend = 0
  - all rvalid and rdata outputs = 0
  - cpu_gnt, ldr_gnt, mem_en, mem_we = 0 while in reset (grants are masked during reset)
- Reset mid-read: the pending rvalid is dropped and never appears after reset deasserts.
- Reset release: the first grant can occur in the first cycle with reset = 1.
- Simultaneous read and write requests: the policy ignores we. Only requester identity matters.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined:
  - Contention is resolved by alternation: the winner is the requester that is not last_owner.
  - last_owner updates on every grant.
  - burst_cnt and MAXBURST are not used (the logic is compiled out).
- Not defined: loader-priority policy with the MAXBURST guard, as above.
  - last_owner is still kept but does not affect arbitration.

## Test plan
- Reset, then cpu_req = 1 read at addr 0x10, memory holds 0x5A at 0x10 -> cpu_gnt = 1 in the same cycle; cpu_rvalid = 1 and cpu_rdata = 0x5A in the next cycle; ldr_rvalid stays 0.
- Loader writes 0xA5 to 0x20, then the core reads 0x20 -> mem_we = 1 on the first grant only; the core reads back 0xA5.
- Both request continuously, MAXBURST = 4, default build -> grant pattern L,L,L,L,C,L,L,L,L,C…; no cycle with both gnt = 1.
- Same stimulus with DMEM_ARB_ROUND_ROBIN_EN -> grants alternate L,C,L,C… starting from the loader after reset (last_owner = 0).
- Core read granted, then reset pulled low before the next edge and released 2 cycles later -> cpu_rvalid never goes to 1; all outputs are 0 during reset.
- Loader only, 8 back-to-back reads of 0x00–0x07 -> 8 consecutive ldr_rvalid pulses with the correct data; burst_cnt stays 0 because cpu_req = 0.
